// File: rtl/tamagotchi_btn_input.sv
// Button front end for tamagotchi_fsm: synchronise and debounce six raw buttons,
// emit care-button press pulses, and time the reset/test holds in whole seconds.
module tamagotchi_btn_input #(
  parameter int TICK_CYCLES     = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_SECONDS    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_salud,
  input  logic       raw_energia,
  input  logic       raw_hambre,
  input  logic       raw_diversion,
  input  logic       raw_reset,
  input  logic       raw_test,
  output logic       btn_salud,
  output logic       btn_energia,
  output logic       btn_hambre,
  output logic       btn_diversion,
  output logic       btn_reset,
  output logic       btn_test,
  output logic [2:0] count_reset,
  output logic [2:0] count_test
);

  localparam int NB = 6;
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [2:0]    HOLD      = 3'(HOLD_SECONDS);

  // Bit order: salud, energia, hambre, diversion, reset, test (LSB first).
  logic [NB-1:0] raw, sync1, s, deb;
  logic [3:0]    deb_q, rise, grant;
  logic [DW-1:0] deb_cnt [NB];
  logic [PW-1:0] pre [2];
  logic [2:0]    cnt [2];
  logic [1:0]    wrap, hit;

  assign raw = {raw_test, raw_reset, raw_diversion, raw_hambre, raw_energia, raw_salud};

  // NOTE: the debounce counter array is cleared element by element in reset;
  // it is control state, so a stale value after reset could fake a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      s     <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < NB; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
      deb_q <= deb[3:0];
      for (int i = 0; i < NB; i++) begin
        if (s[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= s[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise = deb[3:0] & ~deb_q;

  // NOTE: grant gets a default before the priority chain so no latch is inferred.
  always_comb begin
    grant = '0;
    if      (rise[0]) grant[0] = 1'b1;
    else if (rise[1]) grant[1] = 1'b1;
    else if (rise[2]) grant[2] = 1'b1;
    else if (rise[3]) grant[3] = 1'b1;
  end

  always_comb begin
    wrap = '0;
    hit  = '0;
    for (int j = 0; j < 2; j++) begin
      wrap[j] = deb[4+j] && (pre[j] == TICK_LAST);
      hit[j]  = wrap[j] && (cnt[j] == HOLD - 3'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {btn_diversion, btn_hambre, btn_energia, btn_salud} <= '0;
      btn_reset <= 1'b0;
      btn_test  <= 1'b0;
      for (int j = 0; j < 2; j++) begin
        pre[j] <= '0;
        cnt[j] <= '0;
      end
    end else begin
      {btn_diversion, btn_hambre, btn_energia, btn_salud} <= grant;
      btn_reset <= hit[0];
      // A simultaneous finish belongs to reset; test's count is saturated, so it cannot fire later.
      btn_test  <= hit[1] & ~hit[0];
      for (int j = 0; j < 2; j++) begin
        if (!deb[4+j]) begin
          pre[j] <= '0;
          cnt[j] <= '0;
        end else if (wrap[j]) begin
          pre[j] <= '0;
          if (cnt[j] != HOLD) cnt[j] <= cnt[j] + 3'd1;
        end else begin
          pre[j] <= pre[j] + 1'b1;
        end
      end
    end
  end

  assign count_reset = cnt[0];
  assign count_test  = cnt[1];

endmodule

// File: tb/tb_tamagotchi_btn_input.sv
// Directed bench for tamagotchi_btn_input with DEBOUNCE_CYCLES=4, TICK_CYCLES=10,
// HOLD_SECONDS=5; expected edge numbers are counted from the first edge after a raw change.
module tb_tamagotchi_btn_input;

  logic       clk = 1'b0;
  logic       rst;
  logic       raw_salud, raw_energia, raw_hambre, raw_diversion, raw_reset, raw_test;
  logic       btn_salud, btn_energia, btn_hambre, btn_diversion, btn_reset, btn_test;
  logic [2:0] count_reset, count_test;

  int checks = 0;
  int errors = 0;

  tamagotchi_btn_input #(
    .TICK_CYCLES(10),
    .DEBOUNCE_CYCLES(4),
    .HOLD_SECONDS(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .raw_salud(raw_salud),
    .raw_energia(raw_energia),
    .raw_hambre(raw_hambre),
    .raw_diversion(raw_diversion),
    .raw_reset(raw_reset),
    .raw_test(raw_test),
    .btn_salud(btn_salud),
    .btn_energia(btn_energia),
    .btn_hambre(btn_hambre),
    .btn_diversion(btn_diversion),
    .btn_reset(btn_reset),
    .btn_test(btn_test),
    .count_reset(count_reset),
    .count_test(count_test)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] all_out();
    return {btn_salud, btn_energia, btn_hambre, btn_diversion, btn_reset, btn_test,
            count_reset, count_test};
  endfunction

  // Seconds held k edges after the raw press: deb rises after edge 5, one second per 10 edges.
  function automatic int exp_hold(int k);
    int v;
    v = (k < 15) ? 0 : (k - 5) / 10;
    return (v > 5) ? 5 : v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    {raw_salud, raw_energia, raw_hambre, raw_diversion, raw_reset, raw_test} = '0;
    #1;
    checks++;
    if (all_out() !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 000", all_out());
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_press_pulse();
    int pulses = 0;
    int first = -1;
    bit other = 0;
    raw_salud = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (btn_salud) begin
        pulses++;
        if (first < 0) first = k;
      end
      if ({btn_energia, btn_hambre, btn_diversion, btn_reset, btn_test, count_reset, count_test} != 0)
        other = 1;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL salud_pulse_count: got %0d expected 1", pulses);
    end
    checks++;
    if (first != 6) begin
      errors++;
      $display("FAIL salud_pulse_edge: got %0d expected 6", first);
    end
    checks++;
    if (other) begin
      errors++;
      $display("FAIL salud_other_outputs: got nonzero expected 0");
    end
    raw_salud = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (btn_salud) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL salud_release_pulse: got %0d expected 0", pulses);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    raw_energia = 1'b1;
    tick();
    tick();
    tick();
    raw_energia = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (btn_energia) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL energia_glitch: got %0d pulses expected 0", pulses);
    end
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) raw_energia = ~raw_energia;
      tick();
      if (btn_energia) pulses++;
    end
    raw_energia = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (btn_energia) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL energia_toggle: got %0d pulses expected 0", pulses);
    end
  endtask

  task automatic test_priority();
    int ph = 0;
    int pd = 0;
    raw_hambre    = 1'b1;
    raw_diversion = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (btn_hambre) ph++;
      if (btn_diversion) pd++;
    end
    checks++;
    if (ph != 1) begin
      errors++;
      $display("FAIL priority_hambre: got %0d pulses expected 1", ph);
    end
    checks++;
    if (pd != 0) begin
      errors++;
      $display("FAIL priority_diversion: got %0d pulses expected 0", pd);
    end
    raw_hambre    = 1'b0;
    raw_diversion = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_hold_reset();
    int pulses = 0;
    int first = -1;
    raw_reset = 1'b1;
    for (int k = 0; k < 80; k++) begin
      tick();
      checks++;
      if (int'(count_reset) != exp_hold(k)) begin
        errors++;
        $display("FAIL hold_count edge %0d: got %0d expected %0d", k, count_reset, exp_hold(k));
      end
      checks++;
      if (btn_reset !== (k == 55)) begin
        errors++;
        $display("FAIL hold_pulse edge %0d: got %b expected %b", k, btn_reset, k == 55);
      end
    end
    raw_reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (int'(count_reset) != ((k <= 5) ? 5 : 0)) begin
        errors++;
        $display("FAIL release_count edge %0d: got %0d expected %0d", k, count_reset, (k <= 5) ? 5 : 0);
      end
    end
    repeat (10) tick();
    raw_reset = 1'b1;
    for (int k = 0; k < 70; k++) begin
      tick();
      if (btn_reset) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (pulses != 1 || first != 55) begin
      errors++;
      $display("FAIL second_hold: got %0d pulses at edge %0d expected 1 at 55", pulses, first);
    end
    raw_reset = 1'b0;
    repeat (15) tick();
  endtask

  task automatic test_simultaneous();
    int tp = 0;
    raw_reset = 1'b1;
    raw_test  = 1'b1;
    for (int k = 0; k < 70; k++) begin
      tick();
      checks++;
      if (int'(count_reset) != exp_hold(k) || int'(count_test) != exp_hold(k)) begin
        errors++;
        $display("FAIL both_counts edge %0d: got %0d/%0d expected %0d", k, count_reset, count_test, exp_hold(k));
      end
      checks++;
      if (btn_reset !== (k == 55)) begin
        errors++;
        $display("FAIL both_reset_pulse edge %0d: got %b expected %b", k, btn_reset, k == 55);
      end
      if (btn_test) tp++;
    end
    checks++;
    if (tp != 0) begin
      errors++;
      $display("FAIL both_test_suppressed: got %0d pulses expected 0", tp);
    end
    raw_reset = 1'b0;
    raw_test  = 1'b0;
    repeat (15) tick();
  endtask

  task automatic test_reset_mid_hold();
    raw_test = 1'b1;
    repeat (36) tick();
    checks++;
    if (count_test !== 3'd3) begin
      errors++;
      $display("FAIL mid_hold_count: got %0d expected 3", count_test);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (all_out() !== 12'h000) begin
      errors++;
      $display("FAIL mid_hold_async_clear: got %h expected 000", all_out());
    end
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      checks++;
      if (int'(count_test) != exp_hold(k)) begin
        errors++;
        $display("FAIL restart_count edge %0d: got %0d expected %0d", k, count_test, exp_hold(k));
      end
      checks++;
      if (btn_test !== (k == 55)) begin
        errors++;
        $display("FAIL restart_pulse edge %0d: got %b expected %b", k, btn_test, k == 55);
      end
    end
    raw_test = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    test_reset();
    test_press_pulse();
    test_glitch();
    test_priority();
    test_hold_reset();
    test_simultaneous();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
